// File: rtl/hilo_muldiv_controller.sv
// HI/LO multiply-divide unit: MUL/MULU/DIV/DIVU iterate one radix-2 step per cycle, MFHI/MFLO read combinationally.
// Latency: issue edge, then DATA_WIDTH CALC edges and one FIX edge; hi/lo are valid after edge DATA_WIDTH+1.
// Backpressure: stall_req freezes the pipeline while busy; stall only blocks issue and never pauses an op in flight.
module hilo_muldiv_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5,
  // Op encodings; override to match the ALU_OP_* values of the surrounding pipeline.
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL  = ALU_OP_WIDTH'(12),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MULU = ALU_OP_WIDTH'(13),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV  = ALU_OP_WIDTH'(14),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU = ALU_OP_WIDTH'(15),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MFHI = ALU_OP_WIDTH'(16),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MFLO = ALU_OP_WIDTH'(17)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    stall,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  output logic [DATA_WIDTH-1:0]   rd,
  output logic                    busy,
  output logic                    stall_req,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         counter;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, acc_hi, acc_lo;
  logic                  neg_a, neg_b, is_div;

  logic is_mul_op, is_div_op, is_long, is_signed_op, issue;
  logic [DATA_WIDTH:0]   mul_sum, div_shift, div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo, a_raw;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;

  // Op decode and issue condition.
  always_comb begin
    is_mul_op    = (op == ALU_OP_MUL) || (op == ALU_OP_MULU);
    is_div_op    = (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
    is_long      = is_mul_op || is_div_op;
    is_signed_op = (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    issue        = en && !stall && (state == IDLE) && is_long;
  end

  // Next-state logic; CALC runs until the counter has reached zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = CALC;
      CALC:    if (counter == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step: shift-add multiply (multiplier in acc_lo) or restoring divide (dividend in acc_lo).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_ge    = (div_shift >= {1'b0, b_mag});
    if (is_div) begin
      step_hi = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
      step_lo = {acc_lo[DATA_WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result; divide by zero returns all-ones quotient and the original dividend.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    a_raw    = neg_a ? -a_mag : a_mag;
    if (!is_div) begin
      fix_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      fix_lo = prod_fix[DATA_WIDTH-1:0];
    end else if (b_mag == '0) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_hi = neg_a ? -acc_hi : acc_hi;
      fix_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    end
  end

  // Read port and pipeline-freeze request.
  always_comb begin
    rd = '0;
    if (en && (state == IDLE)) begin
      if (op == ALU_OP_MFHI)      rd = hi;
      else if (op == ALU_OP_MFLO) rd = lo;
    end
    stall_req = en && (state != IDLE) && (is_long || (op == ALU_OP_MFHI) || (op == ALU_OP_MFLO));
  end

  // State, operand latch, iteration registers and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      is_div  <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (issue) begin
            neg_a   <= is_signed_op && rs[DATA_WIDTH-1];
            neg_b   <= is_signed_op && rt[DATA_WIDTH-1];
            a_mag   <= (is_signed_op && rs[DATA_WIDTH-1]) ? -rs : rs;
            b_mag   <= (is_signed_op && rt[DATA_WIDTH-1]) ? -rt : rt;
            acc_hi  <= '0;
            acc_lo  <= (is_signed_op && rs[DATA_WIDTH-1]) ? -rs : rs;
            is_div  <= is_div_op;
            counter <= CW'(DATA_WIDTH - 1);
            busy    <= 1'b1;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (counter != '0) counter <= counter - 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Directed bench for hilo_muldiv_controller: results, latency, stall behaviour, reads and reset abort.
module tb_hilo_muldiv_controller;
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_MUL  = 5'd12;
  localparam logic [4:0] OP_MULU = 5'd13;
  localparam logic [4:0] OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15;
  localparam logic [4:0] OP_MFHI = 5'd16;
  localparam logic [4:0] OP_MFLO = 5'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  op = OP_NOP;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] rd, hi, lo;
  logic        busy, stall_req;

  int checks = 0;
  int errors = 0;
  int cyc, sreq;

  hilo_muldiv_controller dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a long op for one issue edge, then drive the post-issue inputs and count busy / stall_req cycles.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic post_en, input logic [4:0] post_op, input logic post_stall,
                        output int n_busy, output int n_sreq);
    en = 1'b1; op = o; rs = a; rt = b; stall = 1'b0;
    tick();
    en = post_en; op = post_op; stall = post_stall;
    #1;
    n_busy = 0; n_sreq = 0;
    while (busy === 1'b1 && n_busy < 100) begin
      n_busy++;
      if (stall_req === 1'b1) n_sreq++;
      tick();
    end
    stall = 1'b0;
  endtask

  initial begin
    // Reset state.
    en = 1'b1; op = OP_MFHI;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_stall_req", {31'd0, stall_req}, 32'd0);
    rst = 1'b0;
    en = 1'b0; op = OP_NOP;
    tick();

    // stall blocks issue.
    en = 1'b1; op = OP_MULU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF; stall = 1'b1;
    tick(); tick(); tick();
    check("stall_blocks_issue", {31'd0, busy}, 32'd0);

    // MULU max*max.
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("mulu_busy_cycles", cyc, 32'd33);
    check("mulu_hi", hi, 32'hFFFF_FFFE);
    check("mulu_lo", lo, 32'h0000_0001);

    // MUL -7*3 with stall raised during CALC, then reads.
    run_op(OP_MUL, 32'hFFFF_FFF9, 32'd3, 1'b0, OP_NOP, 1'b1, cyc, sreq);
    check("mul_stalled_busy_cycles", cyc, 32'd33);
    check("mul_hi", hi, 32'hFFFF_FFFF);
    check("mul_lo", lo, 32'hFFFF_FFEB);
    en = 1'b1; op = OP_MFLO; #1;
    check("mflo_rd", rd, 32'hFFFF_FFEB);
    check("mflo_no_stall_req", {31'd0, stall_req}, 32'd0);
    op = OP_MFHI; #1;
    check("mfhi_rd", rd, 32'hFFFF_FFFF);
    op = OP_NOP; #1;
    check("ignored_op_rd", rd, 32'd0);
    tick();
    check("ignored_op_no_issue", {31'd0, busy}, 32'd0);
    en = 1'b0;

    // Signed divide, divide by zero, signed overflow.
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("divu0_busy_cycles", cyc, 32'd33);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("div0_signed_lo", lo, 32'hFFFF_FFFF);
    check("div0_signed_hi", hi, 32'hFFFF_FFF9);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // MFHI held during DIV -20/6: stall_req every busy cycle, then remainder read.
    run_op(OP_DIV, 32'hFFFF_FFEC, 32'd6, 1'b1, OP_MFHI, 1'b0, cyc, sreq);
    check("mfhi_hold_busy_cycles", cyc, 32'd33);
    check("mfhi_hold_stall_req_cycles", sreq, 32'd33);
    check("mfhi_hold_rd", rd, 32'hFFFF_FFFE);
    check("mfhi_hold_lo", lo, 32'hFFFF_FFFD);
    check("mfhi_hold_stall_req_idle", {31'd0, stall_req}, 32'd0);
    en = 1'b0; op = OP_NOP;

    // Long op held while busy: no effect on hi/lo, issued on the first idle cycle.
    run_op(OP_MULU, 32'd3, 32'd4, 1'b1, OP_DIVU, 1'b0, cyc, sreq);
    check("held_mulu_hi", hi, 32'd0);
    check("held_mulu_lo", lo, 32'd12);
    tick();
    check("held_divu_issued", {31'd0, busy}, 32'd1);
    en = 1'b0; op = OP_NOP;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; tick(); end
    check("held_divu_busy_cycles", cyc, 32'd33);
    check("held_divu_lo", lo, 32'd0);
    check("held_divu_hi", hi, 32'd3);

    // Reset at cycle 10 of a MULU aborts it.
    en = 1'b1; op = OP_MULU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    tick();
    en = 1'b0; op = OP_NOP;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, OP_NOP, 1'b0, cyc, sreq);
    check("post_rst_busy_cycles", cyc, 32'd33);
    check("post_rst_divu_lo", lo, 32'd14);
    check("post_rst_divu_hi", hi, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
